bitstream_fetch_ctrl: RTL

BITSTREAM_FETCH_CTRL -- requirements
Module: bitstream_fetch_ctrl

---
 rtl/bitstream_fetch_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bitstream_fetch_ctrl.sv
// Entropy-coded byte packer: strips 0xFF00 stuffing, decodes markers, and packs
// bit-reversed bytes into BUS_W words for the input bit buffer.
module bitstream_fetch_ctrl #(
   parameter int BUS_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             buf_request,
   output logic             buf_wr_en,
   output logic [BUS_W-1:0] buf_data,
   output logic             marker_valid,
   output logic [7:0]       marker_code,
   output logic             eoi,
   input  logic             restart
);
   localparam int NB = BUS_W / 8;
   localparam int CW = $clog2(NB + 1);

   typedef enum logic [1:0] {FILL, FF_SEEN, FLUSH, DONE} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NB-1:0][7:0]  word_q, word_d;   // slots hold bytes already bit-reversed
   logic                eoi_pend_q, eoi_pend_d;
   logic                eoi_q, eoi_d;
   logic                mk_vld_q, mk_vld_d;
   logic [7:0]          mk_code_q, mk_code_d;
   logic                full, accept, store;
   logic [7:0]          store_byte;

   function automatic logic [7:0] bitrev8(input logic [7:0] b);
      logic [7:0] r;
      for (int j = 0; j < 8; j++) r[j] = b[7-j];
      return r;
   endfunction

   assign full      = (cnt_q == CW'(NB));
   assign buf_wr_en = !rst && buf_request &&
                      (full || (state_q == FLUSH && cnt_q != '0));
   // A full word frees slot 0 on the same edge it is written, so no bubble.
   assign s_ready   = !rst && (state_q == FILL || state_q == FF_SEEN) &&
                      (!full || buf_wr_en);
   assign accept    = s_valid && s_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = buf_wr_en ? '0 : cnt_q;
      word_d     = word_q;
      eoi_pend_d = eoi_pend_q;
      eoi_d      = eoi_q;
      mk_vld_d   = 1'b0;
      mk_code_d  = mk_code_q;
      store      = 1'b0;
      store_byte = s_data;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               if (s_data == 8'hFF) state_d = FF_SEEN;
               else                 store   = 1'b1;
            end
         end
         FF_SEEN: begin
            if (accept) begin
               if (s_data == 8'h00) begin
                  store      = 1'b1;
                  store_byte = 8'hFF;
                  state_d    = FILL;
               end else if (s_data != 8'hFF) begin
                  mk_vld_d  = 1'b1;
                  mk_code_d = s_data;
                  if (s_data >= 8'hD0 && s_data <= 8'hD7) begin
                     state_d = FLUSH;
                  end else if (s_data == 8'hD9) begin
                     eoi_pend_d = 1'b1;
                     state_d    = FLUSH;
                  end else begin
                     state_d = FILL;
                  end
               end
            end
         end
         FLUSH: begin
            // Wait for the buffer if a partial word is pending; empty word exits at once.
            if (cnt_q == '0 || buf_wr_en) begin
               state_d = eoi_pend_q ? DONE : FILL;
               if (eoi_pend_q) eoi_d = 1'b1;
            end
         end
         DONE: begin
            if (restart) begin
               state_d    = FILL;
               eoi_d      = 1'b0;
               eoi_pend_d = 1'b0;
               cnt_d      = '0;
            end
         end
      endcase
      if (store) begin
         for (int k = 0; k < NB; k++)
            if (cnt_d == CW'(k)) word_d[k] = bitrev8(store_byte);
         cnt_d = cnt_d + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         cnt_q      <= '0;
         word_q     <= '0;
         eoi_pend_q <= 1'b0;
         eoi_q      <= 1'b0;
         mk_vld_q   <= 1'b0;
         mk_code_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         eoi_pend_q <= eoi_pend_d;
         eoi_q      <= eoi_d;
         mk_vld_q   <= mk_vld_d;
         mk_code_q  <= mk_code_d;
      end
   end

   // Unfilled slots are padded with all-ones on a flush write.
   always_comb begin
      buf_data = '0;
      for (int k = 0; k < NB; k++)
         if (buf_wr_en) buf_data[8*k +: 8] = (CW'(k) < cnt_q) ? word_q[k] : 8'hFF;
   end

   assign marker_valid = mk_vld_q;
   assign marker_code  = mk_code_q;
   assign eoi          = eoi_q;
endmodule
